// File: rtl/kyber_ntt_pkg.sv
// Shared definitions for the Kyber NTT sequencer and address generator.
// Mode codes, sequencer states and default pass geometry.
package kyber_ntt_pkg;

  localparam logic [1:0] MODE_NTT     = 2'd0;
  localparam logic [1:0] MODE_INVNTT  = 2'd1;
  localparam logic [1:0] MODE_MULT    = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  localparam int PIPE_LAT_DEF  = 6;
  localparam int LAYER_GAP_DEF = 6;
  localparam int NTT_LAST_DEF  = 223;
  localparam int MULT_LAST_DEF = 143;

  // Pointwise multiply writes back once per 4-slot group inside this window.
  localparam int MULT_WR_FIRST = 12;
  localparam int MULT_WR_LAST  = 139;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    GAP,
    DRAIN,
    DONE
  } seq_state_t;

  function automatic logic is_layered(input logic [1:0] m);
    return (m == MODE_NTT) || (m == MODE_INVNTT);
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth 1-bit valid shift register; turns read slots into write strobes
// aligned with the address generator's write-address delay.
module valid_delay_line #(
  parameter int DEPTH = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/ntt_seq_ctrl.sv
// Pass sequencer for NTT / inverse NTT / pointwise multiply over 256 coefficients.
// Drives the address generator step counter and RAM/butterfly enables.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; illegal mode pulses err
// RUN   | issuing one read per cycle, step counter advancing
// GAP   | inter-layer bubble, counter frozen until the last layer drains
// DRAIN | final pipeline flush, counter frozen
// DONE  | single-cycle completion pulse, busy still high
module ntt_seq_ctrl
  import kyber_ntt_pkg::*;
#(
  parameter int PIPE_LAT  = PIPE_LAT_DEF,
  parameter int LAYER_GAP = LAYER_GAP_DEF,  // must be >= PIPE_LAT
  parameter int NTT_LAST  = NTT_LAST_DEF,
  parameter int MULT_LAST = MULT_LAST_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode_in,
  output logic [1:0] mode,
  output logic [7:0] clk_counter,
  output logic       rd_en,
  output logic       wr_en,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [7:0] NTT_LAST_C  = 8'(NTT_LAST);
  localparam logic [7:0] MULT_LAST_C = 8'(MULT_LAST);
  localparam logic [7:0] GAP_LOAD    = 8'(LAYER_GAP - 1);
  localparam logic [7:0] DRAIN_LOAD  = 8'(PIPE_LAT - 1);
  localparam logic [7:0] MWR_FIRST   = 8'(MULT_WR_FIRST);
  localparam logic [7:0] MWR_LAST    = 8'(MULT_WR_LAST);

  seq_state_t state;
  logic [7:0] tmr;
  logic [7:0] last_ctr;
  logic       dly_wr;
  logic       mult_wr;

  assign last_ctr = is_layered(mode) ? NTT_LAST_C : MULT_LAST_C;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode        <= MODE_NTT;
      clk_counter <= '0;
      rd_en       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      tmr         <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (mode_in == MODE_ILLEGAL) begin
              err <= 1'b1;
            end else begin
              mode        <= mode_in;
              clk_counter <= '0;
              rd_en       <= 1'b1;
              busy        <= 1'b1;
              state       <= RUN;
            end
          end
        end
        RUN: begin
          // LAST is tested first: NTT_LAST also sits on a layer boundary.
          if (clk_counter == last_ctr) begin
            rd_en <= 1'b0;
            tmr   <= DRAIN_LOAD;
            state <= DRAIN;
          end else if (is_layered(mode) && clk_counter[4:0] == 5'd31) begin
            rd_en <= 1'b0;
            tmr   <= GAP_LOAD;
            state <= GAP;
          end else begin
            clk_counter <= clk_counter + 8'd1;
          end
        end
        GAP: begin
          if (tmr == 8'd0) begin
            clk_counter <= clk_counter + 8'd1;
            rd_en       <= 1'b1;
            state       <= RUN;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        DRAIN: begin
          if (tmr == 8'd0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  valid_delay_line #(
    .DEPTH (PIPE_LAT)
  ) u_valid_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rd_en),
    .q     (dly_wr)
  );

  assign mult_wr = rd_en && (clk_counter[1:0] == 2'b11) &&
                   (clk_counter >= MWR_FIRST) && (clk_counter <= MWR_LAST);

  assign wr_en = (mode == MODE_MULT) ? mult_wr : dly_wr;

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Self-checking bench for ntt_seq_ctrl: pass-level vector table, per-cycle
// trace model, and hand sequences for illegal mode, mid-pass reset and busy starts.
module tb_ntt_seq_ctrl;

  localparam int P_LAT  = 6;
  localparam int L_GAP  = 6;
  localparam int BUDGET = 400;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] mode_in;
  logic [1:0] mode;
  logic [7:0] clk_counter;
  logic       rd_en;
  logic       wr_en;
  logic       busy;
  logic       done;
  logic       err;

  int checks;
  int failures;

  logic [1:0] last_mode;
  logic [7:0] last_ctr;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic       dn;
    logic [7:0] ctr;
  } cyc_t;

  cyc_t exp_q[$];

  typedef struct {
    logic [1:0] m;
    int         cycles;
    int         rds;
    int         wrs;
    bit         is_err;
  } vec_t;

  vec_t vecs[4];

  ntt_seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode_in     (mode_in),
    .mode        (mode),
    .clk_counter (clk_counter),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Appends one expected cycle; NTT write strobe is the read strobe P_LAT cycles
  // earlier, MULT writes once per 4-slot group inside the 12..139 window.
  task automatic push_cyc(input logic [1:0] m, input logic rd, input int ctr, input logic dn);
    cyc_t c;
    int   i;
    i     = exp_q.size();
    c.rd  = rd;
    c.dn  = dn;
    c.ctr = 8'(ctr);
    if (m == 2'd2) c.wr = rd && (ctr % 4 == 3) && ctr >= 12 && ctr <= 139;
    else           c.wr = (i >= P_LAT) ? exp_q[i-P_LAT].rd : 1'b0;
    exp_q.push_back(c);
  endtask

  task automatic build_model(input logic [1:0] m);
    int last;
    exp_q.delete();
    if (m == 2'd2) begin
      for (int c = 0; c < 144; c++) push_cyc(m, 1'b1, c, 1'b0);
      last = 143;
    end else begin
      for (int l = 0; l < 7; l++) begin
        for (int s = 0; s < 32; s++) push_cyc(m, 1'b1, l*32 + s, 1'b0);
        if (l < 6) for (int g = 0; g < L_GAP; g++) push_cyc(m, 1'b0, l*32 + 31, 1'b0);
      end
      last = 223;
    end
    for (int d = 0; d < P_LAT; d++) push_cyc(m, 1'b0, last, 1'b0);
    push_cyc(m, 1'b0, last, 1'b1);
  endtask

  // noise: 0 quiet, 1 random start/mode_in while busy, 2 start with MULT every cycle
  task automatic do_pass(input logic [1:0] m, input int noise);
    logic [14:0] act_v, exp_v;
    int          n;
    build_model(m);
    n = exp_q.size();
    @(negedge clk); start = 1'b1; mode_in = m;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_v = {m, exp_q[i].ctr, exp_q[i].rd, exp_q[i].wr, 1'b1, exp_q[i].dn, 1'b0};
      act_v = {mode, clk_counter, rd_en, wr_en, busy, done, err};
      check("pass_cycle", 32'(act_v), 32'(exp_v));
      if (noise == 1 && i < n-1) begin
        start   = 1'($urandom_range(0, 1));
        mode_in = 2'($urandom_range(0, 3));
      end else if (noise == 2 && i < n-1) begin
        start   = 1'b1;
        mode_in = 2'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("pass_idle", 32'({mode, clk_counter, rd_en, wr_en, busy, done, err}),
          32'({m, exp_q[n-1].ctr, 5'b0}));
    last_mode = m;
    last_ctr  = exp_q[n-1].ctr;
  endtask

  task automatic illegal_check();
    @(negedge clk); start = 1'b1; mode_in = 2'd3;
    @(negedge clk); start = 1'b0;
    check("illegal_err", 32'({err, busy, rd_en, wr_en, done, mode, clk_counter}),
          32'({5'b10000, last_mode, last_ctr}));
    @(negedge clk);
    check("illegal_clear", 32'({err, busy, done}), 32'd0);
  endtask

  task automatic run_vector(input vec_t v);
    int n, rds, wrs;
    bit got;
    @(negedge clk); start = 1'b1; mode_in = v.m;
    @(negedge clk); start = 1'b0;
    if (v.is_err) begin
      check("vec_err_pulse", 32'({err, busy, rd_en}), 32'b100);
    end else begin
      n = 0; rds = 0; wrs = 0; got = 1'b0;
      while (n < BUDGET) begin
        n++;
        if (rd_en) rds++;
        if (wr_en) wrs++;
        if (done) begin got = 1'b1; break; end
        @(negedge clk);
      end
      check("vec_done_seen", 32'(got), 32'd1);
      check("vec_cycles", n, v.cycles);
      check("vec_rd_count", rds, v.rds);
      check("vec_wr_count", wrs, v.wrs);
      @(negedge clk);
      check("vec_busy_low", 32'({busy, done}), 32'd0);
      last_mode = v.m;
      last_ctr  = (v.m == 2'd2) ? 8'd143 : 8'd223;
    end
  endtask

  initial begin
    int n, bad;
    logic [1:0] m;
    checks = 0; failures = 0;
    last_mode = 2'd0; last_ctr = 8'd0;
    rst_n = 1'b0; start = 1'b0; mode_in = 2'd0;

    vecs[0] = '{m: 2'd0, cycles: 267, rds: 224, wrs: 224, is_err: 1'b0};
    vecs[1] = '{m: 2'd1, cycles: 267, rds: 224, wrs: 224, is_err: 1'b0};
    vecs[2] = '{m: 2'd2, cycles: 151, rds: 144, wrs: 32,  is_err: 1'b0};
    vecs[3] = '{m: 2'd3, cycles: 0,   rds: 0,   wrs: 0,   is_err: 1'b1};

    repeat (2) @(negedge clk);
    check("reset_state", 32'({mode, clk_counter, rd_en, wr_en, busy, done, err}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vector(vecs[i]);

    // Per-cycle traces for every legal mode.
    do_pass(2'd0, 0);
    do_pass(2'd1, 0);
    do_pass(2'd2, 0);

    // Illegal start then a normal pass.
    illegal_check();
    do_pass(2'd0, 0);

    // Start with MULT held high throughout an NTT pass.
    do_pass(2'd0, 2);

    // Asynchronous reset at counter 100 of an NTT pass.
    @(negedge clk); start = 1'b1; mode_in = 2'd0;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (clk_counter != 8'd100 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_100", 32'(clk_counter), 32'd100);
    #1 rst_n = 1'b0;
    #1 check("rst_async_clear", 32'({mode, clk_counter, rd_en, wr_en, busy, done, err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_mode = 2'd0; last_ctr = 8'd0;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (done || busy || rd_en || wr_en) bad++;
    end
    check("rst_no_done", bad, 0);
    do_pass(2'd0, 0);

    // Randomized passes against the trace model.
    repeat (8) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      m = 2'($urandom_range(0, 3));
      if (m == 2'd3) illegal_check();
      else           do_pass(m, int'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ntt_seq_ctrl.md
Name: ntt_seq_ctrl

Overview:
- Sequencer that drives the address generator's `clk_counter` and `mode` inputs for one NTT, inverse NTT or pointwise-multiply pass over a 256-coefficient polynomial.
- Produces aligned read/write enables for the coefficient RAM and butterfly pipeline.
- Inserts drain bubbles between layers so a layer never reads data the previous layer has not yet written.
- Sits between the Kyber top-level command interface and the address generator / butterfly datapath.

Parameters:
- `PIPE_LAT`, 6: cycles from read issue to the write of the same address; matches the address generator's write-address delay line.
- `LAYER_GAP`, 6: bubble cycles inserted after each NTT/INVNTT layer; must be ≥ `PIPE_LAT`.
- `NTT_LAST`, 223: final counter value for NTT/INVNTT (7 layers × 32 butterfly slots).
- `MULT_LAST`, 143: final counter value for MULT.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `mode_in`  in  2  operation: 0 = NTT, 1 = INVNTT, 2 = MULT, 3 = illegal.
- `mode`  out  2  mode latched at start; drives the address generator.
- `clk_counter`  out  8  step counter; drives the address generator.
- `rd_en`  out  1  the current `clk_counter` value is a valid read slot.
- `wr_en`  out  1  write-back strobe, valid in the cycle `w_addr` is valid.
- `busy`  out  1  high from the accepted start until the `done` cycle, inclusive.
- `done`  out  1  one-cycle pulse at pass completion.
- `err`  out  1  one-cycle pulse when a start carries `mode_in` = 3.

Behaviour:
- Reset (asynchronous, `rst_n` = 0):
  - State = IDLE.
  - `clk_counter`, `mode`, `rd_en`, `wr_en`, `busy`, `done`, `err` all = 0.
  - Valid shift register cleared.
  - Reset mid-pass abandons the pass with no `done`; RAM content is don't-care.
- State IDLE:
  - `start` = 1 and `mode_in` ≠ 3 → latch `mode`, `clk_counter` = 0, go to RUN.
  - `start` = 1 and `mode_in` = 3 → pulse `err` next cycle, stay in IDLE, all other outputs unchanged.
- State RUN:
  - `rd_en` = 1.
  - `clk_counter` increments by 1 each cycle.
  - NTT/INVNTT: when `clk_counter[4:0]` = 31 and `clk_counter` ≠ `NTT_LAST` → go to GAP, counter holds its value.
  - When `clk_counter` reaches LAST for the mode (`NTT_LAST` or `MULT_LAST`) → go to DRAIN after that cycle.
- State GAP:
  - `rd_en` = 0; counter frozen.
  - Gap counter runs `LAYER_GAP` cycles, then `clk_counter` += 1 (next layer, `[4:0]` = 0) and return to RUN.
- State DRAIN:
  - `rd_en` = 0; counter frozen.
  - Lasts `PIPE_LAT` cycles, then go to DONE.
- State DONE:
  - `done` = 1 and `busy` = 1 for exactly one cycle, then IDLE with `busy` = 0.
- Enable timing:
  - NTT/INVNTT: `wr_en` = `rd_en` delayed by exactly `PIPE_LAT` cycles through a shift register that shifts every cycle, including GAP and DRAIN. Frozen-counter cycles therefore produce `wr_en` = 0 for the duplicated addresses.
  - MULT: `wr_en` = 1 when `rd_en` = 1, `clk_counter[1:0]` = 3 and 12 ≤ `clk_counter` ≤ 139. This gives exactly 32 writes at `w_addr` 0..31.
- `start` while `busy`: ignored, no `err`, no effect on the pass.
- `mode` is stable for the whole pass; `mode_in` changes after start are ignored.
- Cycle counts from start to done pulse, inclusive of the DONE cycle:
  - NTT/INVNTT: 224 RUN + 6×`LAYER_GAP` + `PIPE_LAT` + 1 = 267 with defaults.
  - MULT: 144 + `PIPE_LAT` + 1 = 151.
- The counter never wraps past LAST; the 8-bit width is sufficient for all modes.

Decomposition:
- Shared package `kyber_ntt_pkg`:
  - mode constants `MODE_NTT`, `MODE_INVNTT`, `MODE_MULT`;
  - state enum IDLE/RUN/GAP/DRAIN/DONE;
  - `NTT_LAST`, `MULT_LAST`, `PIPE_LAT` defaults.
- The address generator uses the same mode constants from this package.
- One natural sub-module, `valid_delay_line`: a `PIPE_LAT`-deep 1-bit shift register with asynchronous active-low clear, producing `wr_en` from `rd_en`.

Test Plan:
- NTT pass: reset, `start` with `mode_in` = 0 → `busy` for 267 cycles. `rd_en` high for 224 cycles in 7 bursts of 32, separated by 6-cycle gaps. `wr_en` is the same pattern shifted +6. `done` pulses at cycle 267.
- INVNTT pass: `mode_in` = 1 → identical enable timing. `mode` output = 1 throughout. Counter sequence is 0..223 with holds at 31, 63, …, 191.
- MULT pass: `mode_in` = 2 → 144 read cycles, exactly 32 `wr_en` pulses at counters 15, 19, …, 139. `done` at cycle 151.
- Illegal mode: `start` with `mode_in` = 3 in IDLE → `err` pulse, `busy` stays 0. A subsequent `start` with `mode_in` = 0 runs a normal pass.
- Reset mid-pass: assert `rst_n` = 0 at `clk_counter` = 100 during NTT → all outputs 0 immediately (asynchronous). No `done` follows. A new start after release completes normally.
- Start while busy: pulse `start` with `mode_in` = 2 during an NTT pass → `mode` stays 0 and the pass length is still 267.
